// File: rtl/ctrl_packet_encoder.sv
// Command queue feeding a packet-issue FSM; tracks per-unit compute busy flags.
// Define CTRL_PACKET_ENCODER_PERF_CNT_EN to add the pkt_count / stall_count outputs.
module ctrl_packet_encoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_UNITS  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [13:0]          cmd,
  output logic                 pkt_valid,
  input  logic                 pkt_ready,
  output logic [13:0]          pkt,
  input  logic [NUM_UNITS-1:0] unit_done,
  output logic [NUM_UNITS-1:0] unit_busy
`ifdef CTRL_PACKET_ENCODER_PERF_CNT_EN
  ,
  output logic [15:0]          pkt_count,
  output logic [15:0]          stall_count
`endif
);

  localparam int         AW      = $clog2(FIFO_DEPTH);
  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_COMP = 2'b11;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_UNIT} state_e;

  state_e               state_q, state_d;
  logic [AW:0]          wr_ptr_q, rd_ptr_q, count;
  logic [AW-1:0]        next_idx;
  logic [13:0]          mem_q [FIFO_DEPTH];
  logic [13:0]          pkt_q, pkt_d, head, next_head;
  logic [NUM_UNITS-1:0] unit_busy_q, unit_busy_d, busy_set;
  logic                 full, empty, push, pop, load_pkt, handshake;
  logic                 head_xmit, head_stall, next_avail, next_xmit, next_stall;

  function automatic logic is_xmit(input logic vld, input logic [1:0] op);
    return vld && (op != OP_NOP);
  endfunction

  function automatic logic is_busy(input logic [NUM_UNITS-1:0] vec, input logic [1:0] id);
    is_busy = 1'b0;
    for (int i = 0; i < NUM_UNITS; i++)
      if (int'(id) == i) is_busy = vec[i];
  endfunction

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign count     = wr_ptr_q - rd_ptr_q;
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign next_idx  = rd_ptr_q[AW-1:0] + AW'(1);
  assign head      = mem_q[rd_ptr_q[AW-1:0]];
  assign next_head = mem_q[next_idx];

  assign pkt_valid = (state_q == ISSUE);
  assign handshake = pkt_valid && pkt_ready;

  always_comb begin
    busy_set = '0;
    for (int i = 0; i < NUM_UNITS; i++)
      busy_set[i] = handshake && (pkt_q[11:10] == OP_COMP) && (int'(pkt_q[13:12]) == i);
  end

  // A compute issued in the same cycle as its unit's done pulse leaves the unit busy.
  assign unit_busy_d = (unit_busy_q & ~unit_done) | busy_set;

  assign head_xmit  = is_xmit(head[3], head[11:10]);
  assign head_stall = is_busy(unit_busy_q, head[13:12]);
  assign next_avail = (count > (AW+1)'(1));
  assign next_xmit  = is_xmit(next_head[3], next_head[11:10]);
  assign next_stall = is_busy(unit_busy_d, next_head[13:12]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (!empty && head_xmit) state_d = head_stall ? WAIT_UNIT : ISSUE;
      WAIT_UNIT: if (!head_stall) state_d = ISSUE;
      ISSUE: begin
        if (pkt_ready) begin
          if (!next_avail || !next_xmit) state_d = IDLE;
          else                           state_d = next_stall ? WAIT_UNIT : ISSUE;
        end
      end
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    pop      = 1'b0;
    load_pkt = 1'b0;
    pkt_d    = head;
    unique case (state_q)
      IDLE: begin
        pop      = !empty && !head_xmit;
        load_pkt = (state_d == ISSUE);
      end
      WAIT_UNIT: load_pkt = (state_d == ISSUE);
      ISSUE: begin
        pop      = pkt_ready;
        load_pkt = pkt_ready && (state_d == ISSUE);
        pkt_d    = next_head;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pkt_q       <= 14'h0;
      unit_busy_q <= '0;
    end else begin
      if (push)     wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)      rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      if (load_pkt) pkt_q    <= pkt_d;
      unit_busy_q <= unit_busy_d;
    end
  end

  // NOTE: queue storage is not reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= cmd;
  end

  assign pkt       = pkt_q;
  assign unit_busy = unit_busy_q;

`ifdef CTRL_PACKET_ENCODER_PERF_CNT_EN
  logic [15:0] pkt_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_q   <= 16'h0;
      stall_cnt_q <= 16'h0;
    end else begin
      if (handshake && (pkt_cnt_q != 16'hFFFF))
        pkt_cnt_q <= pkt_cnt_q + 16'd1;
      if ((state_q == WAIT_UNIT) && (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign pkt_count   = pkt_cnt_q;
  assign stall_count = stall_cnt_q;
`else
  // Counter-free build: no performance ports exist.
`endif

endmodule
